// File: rtl/fib_burst_sequencer.sv
// fib_burst_sequencer
// Replays a burst of words from an external pattern buffer onto registered
// data/clock/sync pins. Each word takes two cycles (clock low, clock high).
// A run is a number of bursts with optional idle gaps, started by a rising
// trigger edge and ended by the burst count, an abort, or reset.
// Output registers follow the FSM state one cycle later, so the first word
// appears one edge after the trigger edge is taken.
module fib_burst_sequencer #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 7,
   parameter int LEN_W  = 10,
   parameter int REP_W  = 8,
   parameter int GAP_W  = 16
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic              trig,
   input  logic              abort,
   input  logic              clr_mode,
   input  logic              clr_2_one,
   input  logic [LEN_W-1:0]  seq_length,
   input  logic [REP_W-1:0]  rep_count,
   input  logic [GAP_W-1:0]  gap_len,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] dout,
   output logic              dclk,
   output logic              syn,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, GAP} state_t;

   // Longest burst the buffer can hold; larger requests are clamped to it.
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

   state_t              state_reg, state_next;
   logic                trig_prev_reg;
   logic [LEN_W-1:0]    len_reg;
   logic [REP_W-1:0]    rep_reg;
   logic [GAP_W-1:0]    gap_reg;
   logic [ADDR_W-1:0]   idx_reg;
   logic [REP_W:0]      cnt_reg;
   logic [GAP_W-1:0]    gap_cnt_reg;
   logic [DATA_W-1:0]   last_word_reg;
   logic                fin_reg;

   logic [DATA_W-1:0]   dout_reg, dout_next;
   logic                dclk_reg, dclk_next;
   logic                syn_reg, syn_next;
   logic                busy_reg, busy_next;
   logic                done_reg, done_next;

   logic                trig_rise;
   logic                start;
   logic                word_last;
   logic [REP_W:0]      cnt_inc;
   logic                run_end;
   logic [DATA_W-1:0]   idle_val;
   logic [LEN_W-1:0]    len_clamped;

   // Shared decode: trigger edge, last word of burst, end of run, idle level.
   always_comb begin
      trig_rise   = trig & ~trig_prev_reg;
      start       = (state_reg == IDLE) && trig_rise && (seq_length != '0) && !abort;
      word_last   = ({{(LEN_W-ADDR_W){1'b0}}, idx_reg} == (len_reg - LEN_W'(1)));
      cnt_inc     = cnt_reg + (REP_W+1)'(1);
      run_end     = (rep_reg != '0) && (cnt_inc == {1'b0, rep_reg});
      idle_val    = clr_2_one ? {DATA_W{1'b1}} : (clr_mode ? {DATA_W{1'b0}} : last_word_reg);
      len_clamped = (seq_length > MAX_LEN) ? MAX_LEN : seq_length;
   end

   assign rd_addr = idx_reg;

   // FSM state register.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM next-state logic; abort overrides every transition.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = SHIFT_LO;
            end
         end
         SHIFT_LO: begin
            state_next = SHIFT_HI;
         end
         SHIFT_HI: begin
            if (!word_last) begin
               state_next = SHIFT_LO;
            end else if (run_end) begin
               state_next = IDLE;
            end else if (gap_reg == '0) begin
               state_next = SHIFT_LO;
            end else begin
               state_next = GAP;
            end
         end
         GAP: begin
            if (gap_cnt_reg == GAP_W'(1)) begin
               state_next = SHIFT_LO;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (abort) begin
         state_next = IDLE;
      end
   end

   // FSM output logic: pin values for the current state, registered below.
   always_comb begin
      dout_next = idle_val;
      dclk_next = 1'b0;
      syn_next  = 1'b0;
      busy_next = 1'b0;
      done_next = 1'b0;
      case (state_reg)
         IDLE: begin
            done_next = fin_reg;
         end
         SHIFT_LO: begin
            dout_next = rd_data;
            syn_next  = (idx_reg == '0);
            busy_next = 1'b1;
         end
         SHIFT_HI: begin
            dout_next = dout_reg;
            dclk_next = 1'b1;
            syn_next  = syn_reg;
            busy_next = 1'b1;
         end
         GAP: begin
            busy_next = 1'b1;
         end
         default: begin
            busy_next = 1'b0;
         end
      endcase
   end

   // Output pin registers.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         dout_reg <= '0;
         dclk_reg <= 1'b0;
         syn_reg  <= 1'b0;
         busy_reg <= 1'b0;
         done_reg <= 1'b0;
      end else begin
         dout_reg <= dout_next;
         dclk_reg <= dclk_next;
         syn_reg  <= syn_next;
         busy_reg <= busy_next;
         done_reg <= done_next;
      end
   end

   assign dout = dout_reg;
   assign dclk = dclk_reg;
   assign syn  = syn_reg;
   assign busy = busy_reg;
   assign done = done_reg;

   // Run parameters, word index, burst and gap counters, trigger history.
   // trig history resets high so a trigger held through reset is not an edge.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         trig_prev_reg <= 1'b1;
         len_reg       <= '0;
         rep_reg       <= '0;
         gap_reg       <= '0;
         idx_reg       <= '0;
         cnt_reg       <= '0;
         gap_cnt_reg   <= '0;
         last_word_reg <= '0;
         fin_reg       <= 1'b0;
      end else begin
         trig_prev_reg <= trig;
         fin_reg       <= (state_reg == SHIFT_HI) && word_last && run_end && !abort;
         if (state_reg == SHIFT_LO) begin
            last_word_reg <= rd_data;
         end
         if (abort) begin
            idx_reg <= '0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (start) begin
                     len_reg <= len_clamped;
                     rep_reg <= rep_count;
                     gap_reg <= gap_len;
                     idx_reg <= '0;
                     cnt_reg <= '0;
                  end
               end
               SHIFT_HI: begin
                  if (word_last) begin
                     idx_reg     <= '0;
                     cnt_reg     <= cnt_inc;
                     gap_cnt_reg <= gap_reg;
                  end else begin
                     idx_reg <= idx_reg + ADDR_W'(1);
                  end
               end
               GAP: begin
                  gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fib_burst_sequencer.sv
// Directed testbench for fib_burst_sequencer: buffer modelled as a bench
// array, outputs sampled on the falling clock edge.
module tb_fib_burst_sequencer;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 7;
   localparam int LEN_W  = 10;
   localparam int REP_W  = 8;
   localparam int GAP_W  = 16;

   logic              clk_in = 1'b0;
   logic              rst;
   logic              trig;
   logic              abort;
   logic              clr_mode;
   logic              clr_2_one;
   logic [LEN_W-1:0]  seq_length;
   logic [REP_W-1:0]  rep_count;
   logic [GAP_W-1:0]  gap_len;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] dout;
   logic              dclk;
   logic              syn;
   logic              busy;
   logic              done;

   logic [7:0] mem [0:127];
   int nvec = 0;
   int nerr = 0;

   wire [11:0] obs = {dout, dclk, syn, busy, done};

   always #5 clk_in = ~clk_in;

   assign rd_data = mem[rd_addr];

   fib_burst_sequencer #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .REP_W(REP_W), .GAP_W(GAP_W)
   ) dut (
      .clk_in(clk_in), .rst(rst), .trig(trig), .abort(abort),
      .clr_mode(clr_mode), .clr_2_one(clr_2_one),
      .seq_length(seq_length), .rep_count(rep_count), .gap_len(gap_len),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .dout(dout), .dclk(dclk), .syn(syn), .busy(busy), .done(done)
   );

   task automatic test_reset;
      rst = 1'b1; trig = 1'b1; abort = 1'b0; clr_mode = 1'b0; clr_2_one = 1'b0;
      seq_length = 10'd4; rep_count = 8'd1; gap_len = 16'd0;
      repeat (3) @(negedge clk_in);
      nvec++;
      if (obs !== 12'h000) begin
         nerr++;
         $display("FAIL reset_state: got dout=%h dclk=%b syn=%b busy=%b done=%b, want all 0",
                  dout, dclk, syn, busy, done);
      end
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_in);
         nvec++;
         if (obs !== 12'h000) begin
            nerr++;
            $display("FAIL trig_through_reset cyc=%0d: got dout=%h dclk=%b syn=%b busy=%b done=%b, want all 0",
                     c, dout, dclk, syn, busy, done);
         end
      end
      trig = 1'b0;
      @(negedge clk_in);
      $display("test_reset done");
   endtask

   task automatic test_single_burst;
      logic [11:0] exp_v;
      seq_length = 10'd4; rep_count = 8'd1; gap_len = 16'd0;
      trig = 1'b1;
      @(negedge clk_in);
      nvec++;
      if (obs !== 12'h000) begin
         nerr++;
         $display("FAIL start_latency: got dout=%h dclk=%b syn=%b busy=%b, want idle zeros", dout, dclk, syn, busy);
      end
      // Changing the run inputs after the trigger edge must not affect this run.
      seq_length = 10'd1; rep_count = 8'd0; gap_len = 16'd7;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk_in);
         exp_v = {mem[c/2], 1'(c % 2), (c < 2), 1'b1, 1'b0};
         nvec++;
         if (obs !== exp_v) begin
            nerr++;
            $display("FAIL single_burst cyc=%0d: got dout=%h dclk=%b syn=%b busy=%b done=%b, want dout=%h dclk=%b syn=%b busy=%b done=%b",
                     c, dout, dclk, syn, busy, done, exp_v[11:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
         end
      end
      @(negedge clk_in);
      nvec++;
      if (obs !== {8'h44, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         nerr++;
         $display("FAIL single_done: got dout=%h dclk=%b syn=%b busy=%b done=%b, want dout=44 dclk=0 syn=0 busy=0 done=1",
                  dout, dclk, syn, busy, done);
      end
      @(negedge clk_in);
      nvec++;
      if (obs !== {8'h44, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         nerr++;
         $display("FAIL single_after_done: got dout=%h busy=%b done=%b, want dout=44 busy=0 done=0", dout, busy, done);
      end
      trig = 1'b0; seq_length = 10'd4; rep_count = 8'd1; gap_len = 16'd0;
      $display("test_single_burst done");
   endtask

   task automatic test_idle_value;
      logic [7:0] modes_exp [4] = '{8'hFF, 8'h00, 8'h44, 8'hFF};
      logic [1:0] modes     [4] = '{2'b10, 2'b01, 2'b00, 2'b11};
      for (int m = 0; m < 4; m++) begin
         clr_2_one = modes[m][1];
         clr_mode  = modes[m][0];
         @(negedge clk_in);
         nvec++;
         if (dout !== modes_exp[m] || busy !== 1'b0) begin
            nerr++;
            $display("FAIL idle_value clr_2_one=%b clr_mode=%b: got dout=%h busy=%b, want dout=%h busy=0",
                     clr_2_one, clr_mode, dout, busy, modes_exp[m]);
         end
      end
      clr_2_one = 1'b0; clr_mode = 1'b0;
      @(negedge clk_in);
      $display("test_idle_value done");
   endtask

   task automatic test_retrig;
      logic [11:0] exp_v;
      seq_length = 10'd4; rep_count = 8'd1; gap_len = 16'd0;
      trig = 1'b1;
      @(negedge clk_in);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk_in);
         exp_v = {mem[c/2], 1'(c % 2), (c < 2), 1'b1, 1'b0};
         nvec++;
         if (obs !== exp_v) begin
            nerr++;
            $display("FAIL retrig_burst cyc=%0d: got dout=%h dclk=%b syn=%b busy=%b done=%b, want dout=%h dclk=%b syn=%b busy=%b done=%b",
                     c, dout, dclk, syn, busy, done, exp_v[11:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
         end
         if (c == 1) trig = 1'b0;
         if (c == 3) trig = 1'b1;
      end
      @(negedge clk_in);
      nvec++;
      if (busy !== 1'b0 || done !== 1'b1) begin
         nerr++;
         $display("FAIL retrig_done: got busy=%b done=%b, want busy=0 done=1", busy, done);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_in);
         nvec++;
         if (busy !== 1'b0 || done !== 1'b0 || dclk !== 1'b0) begin
            nerr++;
            $display("FAIL retrig_ignored cyc=%0d: got busy=%b done=%b dclk=%b, want 0 0 0", c, busy, done, dclk);
         end
      end
      trig = 1'b0;
      @(negedge clk_in);
      $display("test_retrig done");
   endtask

   task automatic test_gap;
      logic [11:0] exp_v;
      seq_length = 10'd2; rep_count = 8'd3; gap_len = 16'd5;
      trig = 1'b1;
      @(negedge clk_in);
      trig = 1'b0;
      for (int b = 0; b < 3; b++) begin
         for (int w = 0; w < 4; w++) begin
            @(negedge clk_in);
            exp_v = {mem[w/2], 1'(w % 2), (w < 2), 1'b1, 1'b0};
            nvec++;
            if (obs !== exp_v) begin
               nerr++;
               $display("FAIL gap_burst b=%0d w=%0d: got dout=%h dclk=%b syn=%b busy=%b done=%b, want dout=%h dclk=%b syn=%b busy=%b done=%b",
                        b, w, dout, dclk, syn, busy, done, exp_v[11:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
            end
         end
         if (b < 2) begin
            for (int g = 0; g < 5; g++) begin
               @(negedge clk_in);
               exp_v = {mem[1], 1'b0, 1'b0, 1'b1, 1'b0};
               nvec++;
               if (obs !== exp_v) begin
                  nerr++;
                  $display("FAIL gap_idle b=%0d g=%0d: got dout=%h dclk=%b syn=%b busy=%b done=%b, want dout=%h dclk=0 syn=0 busy=1 done=0",
                           b, g, dout, dclk, syn, busy, done, exp_v[11:4]);
               end
            end
         end
      end
      @(negedge clk_in);
      nvec++;
      if (busy !== 1'b0 || done !== 1'b1 || dclk !== 1'b0) begin
         nerr++;
         $display("FAIL gap_done: got busy=%b done=%b dclk=%b, want busy=0 done=1 dclk=0", busy, done, dclk);
      end
      @(negedge clk_in);
      nvec++;
      if (done !== 1'b0) begin
         nerr++;
         $display("FAIL gap_done_pulse: got done=%b, want 0", done);
      end
      $display("test_gap done");
   endtask

   task automatic test_continuous_abort;
      logic [11:0] exp_v;
      seq_length = 10'd3; rep_count = 8'd0; gap_len = 16'd0;
      trig = 1'b1;
      @(negedge clk_in);
      trig = 1'b0;
      for (int c = 0; c < 21; c++) begin
         @(negedge clk_in);
         exp_v = {mem[(c/2)%3], 1'(c % 2), ((c/2)%3 == 0), 1'b1, 1'b0};
         nvec++;
         if (obs !== exp_v) begin
            nerr++;
            $display("FAIL continuous cyc=%0d: got dout=%h dclk=%b syn=%b busy=%b done=%b, want dout=%h dclk=%b syn=%b busy=%b done=%b",
                     c, dout, dclk, syn, busy, done, exp_v[11:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
         end
         abort = (c == 19);
      end
      abort = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_in);
         nvec++;
         if (obs !== {mem[1], 1'b0, 1'b0, 1'b0, 1'b0}) begin
            nerr++;
            $display("FAIL abort_idle cyc=%0d: got dout=%h dclk=%b syn=%b busy=%b done=%b, want dout=%h dclk=0 syn=0 busy=0 done=0",
                     c, dout, dclk, syn, busy, done, mem[1]);
         end
      end
      // abort and trigger edge together while idle: nothing starts
      seq_length = 10'd4; rep_count = 8'd1;
      trig = 1'b1; abort = 1'b1;
      @(negedge clk_in);
      abort = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_in);
         nvec++;
         if (busy !== 1'b0 || dclk !== 1'b0 || syn !== 1'b0) begin
            nerr++;
            $display("FAIL abort_beats_trig cyc=%0d: got busy=%b dclk=%b syn=%b, want 0 0 0", c, busy, dclk, syn);
         end
      end
      trig = 1'b0;
      @(negedge clk_in);
      $display("test_continuous_abort done");
   endtask

   task automatic test_zero_len;
      seq_length = 10'd0; rep_count = 8'd1; gap_len = 16'd0;
      trig = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_in);
         nvec++;
         if (busy !== 1'b0 || dclk !== 1'b0 || syn !== 1'b0) begin
            nerr++;
            $display("FAIL zero_len cyc=%0d: got busy=%b dclk=%b syn=%b, want 0 0 0", c, busy, dclk, syn);
         end
      end
      trig = 1'b0;
      @(negedge clk_in);
      $display("test_zero_len done");
   endtask

   task automatic test_clamp;
      logic [11:0] exp_v;
      seq_length = 10'd1023; rep_count = 8'd1; gap_len = 16'd0;
      trig = 1'b1;
      @(negedge clk_in);
      trig = 1'b0;
      for (int c = 0; c < 256; c++) begin
         @(negedge clk_in);
         exp_v = {mem[c/2], 1'(c % 2), (c < 2), 1'b1, 1'b0};
         nvec++;
         if (obs !== exp_v) begin
            nerr++;
            $display("FAIL clamp cyc=%0d: got dout=%h dclk=%b syn=%b busy=%b done=%b, want dout=%h dclk=%b syn=%b busy=%b done=%b",
                     c, dout, dclk, syn, busy, done, exp_v[11:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
         end
      end
      @(negedge clk_in);
      nvec++;
      if (busy !== 1'b0 || done !== 1'b1) begin
         nerr++;
         $display("FAIL clamp_done: got busy=%b done=%b, want busy=0 done=1", busy, done);
      end
      @(negedge clk_in);
      $display("test_clamp done");
   endtask

   task automatic test_rst_mid;
      seq_length = 10'd4; rep_count = 8'd0; gap_len = 16'd0;
      trig = 1'b1;
      @(negedge clk_in);
      trig = 1'b0;
      repeat (5) @(negedge clk_in);
      nvec++;
      if (busy !== 1'b1) begin
         nerr++;
         $display("FAIL rst_mid_running: got busy=%b, want 1", busy);
      end
      #2 rst = 1'b1;
      #1;
      nvec++;
      if (obs !== 12'h000) begin
         nerr++;
         $display("FAIL rst_mid_async: got dout=%h dclk=%b syn=%b busy=%b done=%b, want all 0",
                  dout, dclk, syn, busy, done);
      end
      @(negedge clk_in);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_in);
         nvec++;
         if (obs !== 12'h000) begin
            nerr++;
            $display("FAIL rst_mid_after cyc=%0d: got dout=%h dclk=%b syn=%b busy=%b done=%b, want all 0",
                     c, dout, dclk, syn, busy, done);
         end
      end
      $display("test_rst_mid done");
   endtask

   initial begin
      for (int i = 0; i < 128; i++) begin
         mem[i] = 8'((i * 7 + 3) % 256);
      end
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
      test_reset();
      test_single_burst();
      test_idle_value();
      test_retrig();
      test_gap();
      test_continuous_abort();
      test_zero_len();
      test_clamp();
      test_rst_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
